// File: rtl/temp_readout.sv
// Temperature readout: IIR-averaged window count, hysteretic over-temp alarm, 10-bit serial frame on request.
// avg is visible 1 cycle after win_done; hot follows 1 cycle later; a frame starts the cycle after an accepted rd_req.
module temp_readout #(
  parameter int         AVG_SHIFT = 2,
  parameter logic [7:0] TH_HI     = 8'd200,
  parameter logic [7:0] TH_LO     = 8'd180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] T,
  input  logic       win_done,
  input  logic       rd_req,
  output logic [7:0] avg,
  output logic       hot,
  output logic       new_data,
  output logic       sdo,
  output logic       sdo_vld,
  output logic       busy
);

  localparam int AW = 8 + AVG_SHIFT;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic          first;
  logic          accept;
  logic [9:0]    shreg;
  logic [3:0]    cnt;

  // First sample seeds the filter so avg starts at T rather than ramping from zero.
  always_comb begin
    if (first) acc_nxt = AW'(T) << AVG_SHIFT;
    else       acc_nxt = acc - (acc >> AVG_SHIFT) + AW'(T);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      avg      <= '0;
      hot      <= 1'b0;
      new_data <= 1'b0;
      first    <= 1'b1;
      shreg    <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;

      if (win_done) begin
        acc   <= acc_nxt;
        avg   <= 8'(acc_nxt >> AVG_SHIFT);
        first <= 1'b0;
      end

      if (avg >= TH_HI)      hot <= 1'b1;
      else if (avg <= TH_LO) hot <= 1'b0;

      if (win_done)    new_data <= 1'b1;
      else if (accept) new_data <= 1'b0;

      // Snapshot uses pre-update avg/hot; even parity over the whole frame.
      if (accept) begin
        shreg <= {avg, hot, ^{avg, hot}};
        cnt   <= '0;
      end else if (state == SHIFT) begin
        shreg <= {shreg[8:0], 1'b0};
        cnt   <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    sdo_vld   = 1'b0;
    sdo       = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        sdo_vld = 1'b1;
        sdo     = shreg[9];
        if (cnt == 4'd9) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_temp_readout.sv
// Bench for temp_readout: directed vectors; frame bits checked by a queue-based monitor.
module tb_temp_readout;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] T;
  logic       win_done;
  logic       rd_req;
  logic [7:0] avg;
  logic       hot;
  logic       new_data;
  logic       sdo;
  logic       sdo_vld;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  temp_readout dut (
    .clk(clk), .rst_n(rst_n), .T(T), .win_done(win_done), .rd_req(rd_req),
    .avg(avg), .hot(hot), .new_data(new_data), .sdo(sdo), .sdo_vld(sdo_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [9:0] f);
    for (int i = 9; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic win(input logic [7:0] t);
    T = t; win_done = 1'b1;
    tick();
    win_done = 1'b0; T = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk({name, "_idle_timeout"}, int'(busy), 0);
  endtask

  // Monitor: every valid serial bit must match the next expected bit.
  initial begin
    forever begin
      @(negedge clk);
      if (sdo_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sdo_unexpected: got sdo_vld=1 sdo=%0d expected no frame bit", sdo);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (sdo !== e || busy !== 1'b1) begin
            errors++;
            $display("FAIL sdo_bit: got sdo=%0d busy=%0d expected sdo=%0d busy=1", sdo, busy, e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; T = 8'h00; win_done = 1'b0; rd_req = 1'b0;
    tick(); tick();
    chk("rst_avg", avg, 0);
    chk("rst_hot", hot, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sdo_vld", sdo_vld, 0);
    rst_n = 1'b1;
    tick();

    // Averaging
    win(8'd100); chk("avg_1", avg, 100); chk("new_data_1", new_data, 1);
    win(8'd200); chk("avg_2", avg, 125);
    win(8'd200); chk("avg_3", avg, 143);
    win(8'd200); chk("avg_4", avg, 158);
    tick();

    // Collision: frame carries avg=158 (0x9E), hot=0, par=1
    push_frame(10'b1001111001);
    rd_req = 1'b1; T = 8'd200; win_done = 1'b1;
    tick();
    rd_req = 1'b0; win_done = 1'b0; T = 8'h00;
    chk("coll_busy", busy, 1);
    chk("coll_avg", avg, 168);
    chk("coll_new_data", new_data, 1);
    tick(); tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_idle("coll");
    chk("coll_new_data_after", new_data, 1);
    chk("coll_q_empty", exp_q.size(), 0);

    // Hysteresis
    do_reset();
    win(8'd255); chk("hys_avg_255", avg, 255); chk("hys_hot_lag", hot, 0);
    tick(); chk("hys_hot_set", hot, 1);
    win(8'd0); chk("hys_avg_191", avg, 191);
    tick(); chk("hys_hot_hold", hot, 1);
    win(8'd0); chk("hys_avg_143", avg, 143);
    tick(); chk("hys_hot_clr", hot, 0);

    // Frame 0xA5, then back-to-back request at the return-to-idle cycle
    do_reset();
    win(8'hA5); chk("frm_avg", avg, 8'hA5);
    tick();
    push_frame(10'b1010010100);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("frm_busy", busy, 1);
    chk("frm_new_data_clr", new_data, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("frm_idle_at_end", busy, 0);
    chk("frm_vld_at_end", sdo_vld, 0);
    push_frame(10'b1010010100);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("b2b_busy", busy, 1);

    // Reset at frame bit 4
    tick(); tick(); tick();
    rst_n = 1'b0; win_done = 1'b1; T = 8'd99; rd_req = 1'b1;
    tick();
    chk("rst_mid_q_left", exp_q.size(), 6);
    exp_q.delete();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_vld", sdo_vld, 0);
    chk("rst_mid_avg", avg, 0);
    chk("rst_mid_hot", hot, 0);
    tick();
    rst_n = 1'b1; win_done = 1'b0; rd_req = 1'b0; T = 8'h00;
    tick();
    chk("rst_ignored_avg", avg, 0);
    chk("rst_ignored_busy", busy, 0);
    win(8'd50); chk("rst_first_load", avg, 50);
    tick(); tick();
    chk("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/temp_readout.md
TEMP_READOUT -- requirements
Module: temp_readout

Interface
REQ-001 SHALL have parameter AVG_SHIFT, default 2, IIR averaging shift (weight 1/2^AVG_SHIFT).
REQ-002 SHALL have parameter TH_HI, default 8'd200, alarm set threshold.
REQ-003 SHALL have parameter TH_LO, default 8'd180, alarm clear threshold (TH_LO < TH_HI).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 T  input  8  window pulse count from the upstream comparator counter.
REQ-007 win_done  input  1  one-cycle strobe; T holds the final window count in this cycle.
REQ-008 rd_req  input  1  one-cycle read request for a serial frame.
REQ-009 avg  output  8  averaged temperature code.
REQ-010 hot  output  1  over-temperature alarm, with hysteresis.
REQ-011 new_data  output  1  avg updated since last accepted read.
REQ-012 sdo  output  1  serial frame data.
REQ-013 sdo_vld  output  1  sdo holds a valid frame bit.
REQ-014 busy  output  1  frame transmission in progress.

Function
REQ-015 Accumulator acc SHALL be 8+AVG_SHIFT bits; avg SHALL equal acc >> AVG_SHIFT (truncated), registered.
REQ-016 On the first win_done after reset, acc SHALL load T << AVG_SHIFT.
REQ-017 On each later win_done, acc SHALL load acc - (acc >> AVG_SHIFT) + T; no saturation is needed, because the result never exceeds 255 << AVG_SHIFT.
REQ-018 A win_done in cycle n SHALL make the updated avg visible in cycle n+1; T is sampled only when win_done=1.
REQ-019 hot SHALL update one cycle after avg changes: set when avg >= TH_HI, cleared when avg <= TH_LO, otherwise held.
REQ-020 new_data SHALL set in the cycle avg updates and clear when a rd_req is accepted; if both occur in the same cycle, set wins.
REQ-021 FSM states: IDLE, SHIFT.
- IDLE: busy=0, sdo_vld=0, sdo=0.
- rd_req in IDLE at cycle n -> SHIFT at n+1.
REQ-022 On acceptance, the 10-bit frame SHALL be snapshotted as {avg[7:0], hot, par}, where par makes the total count of ones in the frame even.
- avg and hot are taken as registered at that edge, i.e. before any same-cycle win_done update.
REQ-023 SHIFT SHALL drive one frame bit per cycle, MSB (avg[7]) first, on cycles n+1..n+10.
- sdo_vld=1 and busy=1 on those cycles.
- Return to IDLE at n+11.
REQ-024 rd_req while busy SHALL be ignored (not queued); new_data is not cleared by an ignored request.
REQ-025 win_done during SHIFT SHALL update avg, hot and new_data normally without altering the frame in flight.
REQ-026 A rd_req in the same cycle SHIFT returns to IDLE (cycle n+11) SHALL be accepted.

Reset
REQ-027 While rst_n=0 at a clock edge:
- acc=0, avg=0, hot=0, new_data=0.
- sdo=0, sdo_vld=0, busy=0.
- FSM=IDLE, first-sample flag set.
REQ-028 Reset during SHIFT SHALL abort the frame; sdo_vld=0 from the next cycle.
REQ-029 Inputs SHALL be ignored in any cycle with rst_n=0.

Verification
REQ-030 Averaging: win_done with T=100,200,200,200 -> avg=100,125,143,158; new_data=1 after the first update.
REQ-031 Hysteresis: T=255 -> avg=255, hot=1 next cycle; then T=0 -> avg=191, hot stays 1; T=0 -> avg=143, hot=0.
REQ-032 Frame: avg=0xA5, hot=0, rd_req:
- sdo = 1,0,1,0,0,1,0,1,0,0 over 10 cycles with sdo_vld=1, busy=1.
- Then idle; new_data cleared.
REQ-033 Collision: rd_req and win_done in the same cycle -> frame carries the old avg; new_data=1 afterwards; a second rd_req mid-frame is ignored.
REQ-034 Reset mid-frame: rst_n=0 at frame bit 4 -> busy=0, sdo_vld=0, avg=0, hot=0; the next win_done T=50 gives avg=50 (first-sample load).
